// File: rtl/cpu_param_if.sv
// Instruction/result handshake bundle between a sequencer and cpu_param.
// The bus owner (master) supplies instructions; the CPU (slave) returns results and status.
interface cpu_param_if #(
  parameter int DATA_W = 16
);
  logic              s;
  logic              load;
  logic [15:0]       in;
  logic [DATA_W-1:0] out;
  logic              N;
  logic              V;
  logic              Z;
  logic              w;
  logic              err;

  modport master (output s, load, in, input out, N, V, Z, w, err);
  modport slave  (input s, load, in, output out, N, V, Z, w, err);
endinterface

// File: rtl/cpu_param.sv
// Parametrised multicycle CPU: one 16-bit instruction per start pulse over eight
// DATA_W-bit registers, with status flags and a sticky undefined-opcode flag.
//
// state       | meaning
// S_WAIT      | idle, w=1, waiting for s
// S_DECODE    | latch instruction fields, classify opcode
// S_LOAD_A    | A <= R[Rn]
// S_LOAD_B    | B <= R[Rm]
// S_EXEC      | C <= ALU result, status update
// S_WRITE     | R[Rd] <= C
// S_WRITE_IMM | R[Rn] <= sext(imm8)
module cpu_param #(
  parameter int DATA_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  cpu_param_if.slave  bus
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WRITE,
    S_WRITE_IMM
  } state_e;

  typedef enum logic [2:0] {
    K_UNDEF,
    K_MOVI,
    K_MOVR,
    K_ADD,
    K_CMP,
    K_AND,
    K_MVN
  } klass_e;

  function automatic klass_e classify(input logic [15:0] iw);
    klass_e k;
    k = K_UNDEF;
    case (iw[15:11])
      5'b110_10: k = K_MOVI;
      5'b110_00: k = K_MOVR;
      5'b101_00: k = K_ADD;
      5'b101_01: k = K_CMP;
      5'b101_10: k = K_AND;
      5'b101_11: k = K_MVN;
      default:   k = K_UNDEF;
    endcase
    return k;
  endfunction

  state_e            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       cur_q, cur_d;
  logic [DATA_W-1:0] r_q [8];
  logic [DATA_W-1:0] r_d [8];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic              n_q, n_d;
  logic              v_q, v_d;
  logic              z_q, z_d;
  logic              err_q, err_d;

  // Fields of the executing instruction come from cur_q, frozen at DECODE,
  // so a load into IR mid-instruction cannot disturb it.
  logic [2:0]        rn, rd, rm;
  logic [1:0]        sh;
  logic [DATA_W-1:0] imm_sext;
  klass_e            cls_cur;

  assign rn       = cur_q[10:8];
  assign rd       = cur_q[7:5];
  assign sh       = cur_q[4:3];
  assign rm       = cur_q[2:0];
  assign imm_sext = DATA_W'($signed(cur_q[7:0]));
  assign cls_cur  = classify(cur_q);

  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] alu_res;
  logic              alu_v;
  logic              alu_upd;

  always_comb begin
    b_sh = b_q;
    case (sh)
      2'b01:   b_sh = {b_q[MSB-1:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[MSB:1]};
      2'b11:   b_sh = {b_q[MSB], b_q[MSB:1]};
      default: b_sh = b_q;
    endcase
  end

  always_comb begin
    alu_res = b_sh;
    alu_v   = 1'b0;
    alu_upd = 1'b1;
    case (cls_cur)
      K_ADD: begin
        alu_res = a_q + b_sh;
        alu_v   = (a_q[MSB] == b_sh[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      K_CMP: begin
        alu_res = a_q - b_sh;
        alu_v   = (a_q[MSB] != b_sh[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      K_AND:   alu_res = a_q & b_sh;
      K_MVN:   alu_res = ~b_sh;
      default: begin
        alu_res = b_sh;
        alu_upd = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = bus.load ? bus.in : ir_q;
    cur_d   = cur_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    err_d   = err_q;
    r_d     = r_q;

    case (state_q)
      S_WAIT: begin
        if (bus.s) state_d = S_DECODE;
      end
      S_DECODE: begin
        cur_d = ir_q;
        case (classify(ir_q))
          K_MOVI:             state_d = S_WRITE_IMM;
          K_ADD, K_CMP, K_AND: state_d = S_LOAD_A;
          K_MOVR, K_MVN:      state_d = S_LOAD_B;
          default: begin
            state_d = S_WAIT;
            err_d   = 1'b1;
          end
        endcase
      end
      S_LOAD_A: begin
        a_d     = r_q[rn];
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_d     = r_q[rm];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d = alu_res;
        if (alu_upd) begin
          n_d = alu_res[MSB];
          z_d = (alu_res == '0);
          v_d = alu_v;
        end
        state_d = (cls_cur == K_CMP) ? S_WAIT : S_WRITE;
      end
      S_WRITE: begin
        r_d[rd] = c_q;
        state_d = S_WAIT;
      end
      S_WRITE_IMM: begin
        r_d[rn] = imm_sext;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      cur_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cur_q   <= cur_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      err_q   <= err_d;
      for (int i = 0; i < 8; i++) r_q[i] <= r_d[i];
    end
  end

  assign bus.out = c_q;
  assign bus.N   = n_q;
  assign bus.V   = v_q;
  assign bus.Z   = z_q;
  assign bus.w   = (state_q == S_WAIT);
  assign bus.err = err_q;

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param at DATA_W=16 and DATA_W=8 with hand-computed results,
// latencies and status flags.
module tb_cpu_param;

  logic clk;
  logic reset16;
  logic reset8;

  cpu_param_if #(.DATA_W(16)) bus16 ();
  cpu_param_if #(.DATA_W(8))  bus8 ();

  cpu_param #(.DATA_W(16)) dut16 (.clk(clk), .reset(reset16), .bus(bus16));
  cpu_param #(.DATA_W(8))  dut8  (.clk(clk), .reset(reset8),  .bus(bus8));

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run16(input logic [15:0] ins, output int lat);
    @(negedge clk);
    bus16.in   = ins;
    bus16.load = 1'b1;
    @(negedge clk);
    bus16.load = 1'b0;
    bus16.s    = 1'b1;
    @(posedge clk);
    #1;
    bus16.s = 1'b0;
    lat = 1;
    while (bus16.w !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [15:0] ins, output int lat);
    @(negedge clk);
    bus8.in   = ins;
    bus8.load = 1'b1;
    @(negedge clk);
    bus8.load = 1'b0;
    bus8.s    = 1'b1;
    @(posedge clk);
    #1;
    bus8.s = 1'b0;
    lat = 1;
    while (bus8.w !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset16 = 1'b1;
    reset8  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset16 = 1'b0;
    reset8  = 1'b0;
    #1;
    n_checks++;
    if (bus16.w !== 1'b1) begin n_fail++; $display("FAIL reset_w16: got %b want 1", bus16.w); end
    n_checks++;
    if (bus16.out !== 16'h0000) begin n_fail++; $display("FAIL reset_out16: got %h want 0000", bus16.out); end
    n_checks++;
    if ({bus16.N, bus16.V, bus16.Z, bus16.err} !== 4'b0000)
      begin n_fail++; $display("FAIL reset_flags16: got NVZ,err=%b want 0000", {bus16.N, bus16.V, bus16.Z, bus16.err}); end
    n_checks++;
    if (bus8.w !== 1'b1 || bus8.out !== 8'h00)
      begin n_fail++; $display("FAIL reset_8: got w=%b out=%h want w=1 out=00", bus8.w, bus8.out); end
  endtask

  task automatic test_add_seq;
    int lat;
    run16(16'hD007, lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL movi_r0_lat: got %0d want 3", lat); end
    run16(16'hD102, lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL movi_r1_lat: got %0d want 3", lat); end
    run16(16'hA148, lat);
    n_checks++;
    if (lat != 6) begin n_fail++; $display("FAIL add_lat: got %0d want 6", lat); end
    n_checks++;
    if (bus16.out !== 16'd16) begin n_fail++; $display("FAIL add_out: got %h want 0010", bus16.out); end
    n_checks++;
    if ({bus16.N, bus16.V, bus16.Z} !== 3'b000)
      begin n_fail++; $display("FAIL add_nvz: got %b want 000", {bus16.N, bus16.V, bus16.Z}); end
    n_checks++;
    if (dut16.r_q[2] !== 16'd16) begin n_fail++; $display("FAIL add_r2: got %h want 0010", dut16.r_q[2]); end
  endtask

  task automatic test_cmp;
    int lat;
    run16(16'hA901, lat);
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL cmp_lat: got %0d want 5", lat); end
    n_checks++;
    if (bus16.out !== 16'h0000 || {bus16.N, bus16.V, bus16.Z} !== 3'b001)
      begin n_fail++; $display("FAIL cmp_res: got out=%h NVZ=%b want 0000/001", bus16.out, {bus16.N, bus16.V, bus16.Z}); end
    n_checks++;
    if (dut16.r_q[2] !== 16'd16 || dut16.r_q[3] !== 16'h0 || dut16.r_q[7] !== 16'h0)
      begin n_fail++; $display("FAIL cmp_nowrite: got r2=%h r3=%h r7=%h want 0010/0000/0000",
                               dut16.r_q[2], dut16.r_q[3], dut16.r_q[7]); end
    run16(16'hD3FF, lat);
    n_checks++;
    if ({bus16.N, bus16.V, bus16.Z} !== 3'b001)
      begin n_fail++; $display("FAIL movi_keeps_status: got NVZ=%b want 001", {bus16.N, bus16.V, bus16.Z}); end
    n_checks++;
    if (dut16.r_q[3] !== 16'hFFFF) begin n_fail++; $display("FAIL movi_r3: got %h want ffff", dut16.r_q[3]); end
  endtask

  task automatic test_overflow_shift;
    int lat;
    run16(16'hD4FF, lat);
    run16(16'hC0B4, lat);
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL movr_lat: got %0d want 5", lat); end
    n_checks++;
    if (dut16.r_q[5] !== 16'h7FFF) begin n_fail++; $display("FAIL lsr_r5: got %h want 7fff", dut16.r_q[5]); end
    run16(16'hA5C5, lat);
    n_checks++;
    if (bus16.out !== 16'hFFFE) begin n_fail++; $display("FAIL ovf_out: got %h want fffe", bus16.out); end
    n_checks++;
    if ({bus16.N, bus16.V, bus16.Z} !== 3'b110)
      begin n_fail++; $display("FAIL ovf_nvz: got %b want 110", {bus16.N, bus16.V, bus16.Z}); end
    run16(16'hC0FE, lat);
    n_checks++;
    if (dut16.r_q[7] !== 16'hFFFF) begin n_fail++; $display("FAIL asr_r7: got %h want ffff", dut16.r_q[7]); end
    n_checks++;
    if ({bus16.N, bus16.V, bus16.Z} !== 3'b110)
      begin n_fail++; $display("FAIL movr_keeps_status: got %b want 110", {bus16.N, bus16.V, bus16.Z}); end
  endtask

  task automatic test_width8;
    int lat;
    run8(16'hD080, lat);
    n_checks++;
    if (dut8.r_q[0] !== 8'h80) begin n_fail++; $display("FAIL w8_movi: got %h want 80", dut8.r_q[0]); end
    run8(16'hB820, lat);
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL w8_mvn_lat: got %0d want 5", lat); end
    n_checks++;
    if (bus8.out !== 8'h7F || {bus8.N, bus8.V, bus8.Z} !== 3'b000)
      begin n_fail++; $display("FAIL w8_mvn: got out=%h NVZ=%b want 7f/000", bus8.out, {bus8.N, bus8.V, bus8.Z}); end
    run8(16'hA040, lat);
    n_checks++;
    if (bus8.out !== 8'h00 || {bus8.N, bus8.V, bus8.Z} !== 3'b011)
      begin n_fail++; $display("FAIL w8_add_ovf: got out=%h NVZ=%b want 00/011", bus8.out, {bus8.N, bus8.V, bus8.Z}); end
    n_checks++;
    if (dut8.r_q[2] !== 8'h00 || dut8.r_q[1] !== 8'h7F)
      begin n_fail++; $display("FAIL w8_regs: got r1=%h r2=%h want 7f/00", dut8.r_q[1], dut8.r_q[2]); end
  endtask

  task automatic test_undefined;
    int lat;
    run16(16'hE000, lat);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL undef_lat: got %0d want 2", lat); end
    n_checks++;
    if (bus16.err !== 1'b1) begin n_fail++; $display("FAIL undef_err: got %b want 1", bus16.err); end
    n_checks++;
    if (dut16.r_q[0] !== 16'd7 || dut16.r_q[7] !== 16'hFFFF || bus16.out !== 16'hFFFF)
      begin n_fail++; $display("FAIL undef_nochange: got r0=%h r7=%h out=%h want 0007/ffff/ffff",
                               dut16.r_q[0], dut16.r_q[7], bus16.out); end
    run16(16'hD00C, lat);
    n_checks++;
    if (lat != 3 || dut16.r_q[0] !== 16'h000C)
      begin n_fail++; $display("FAIL after_undef: got lat=%0d r0=%h want 3/000c", lat, dut16.r_q[0]); end
    n_checks++;
    if (bus16.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", bus16.err); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus16.in   = 16'hD101;
    bus16.load = 1'b1;
    @(negedge clk);
    bus16.load = 1'b0;
    bus16.s    = 1'b1;
    @(posedge clk);
    #1;
    bus16.in   = 16'hD205;
    bus16.load = 1'b1;
    @(posedge clk);
    #1;
    bus16.load = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus16.w !== 1'b1 || dut16.r_q[1] !== 16'h0001)
      begin n_fail++; $display("FAIL b2b_first: got w=%b r1=%h want 1/0001", bus16.w, dut16.r_q[1]); end
    @(posedge clk);
    #1;
    bus16.s = 1'b0;
    n_checks++;
    if (bus16.w !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: got w=%b want 0", bus16.w); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus16.w !== 1'b1 || dut16.r_q[2] !== 16'h0005)
      begin n_fail++; $display("FAIL b2b_second: got w=%b r2=%h want 1/0005", bus16.w, dut16.r_q[2]); end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    bus16.in   = 16'hA140;
    bus16.load = 1'b1;
    @(negedge clk);
    bus16.load = 1'b0;
    bus16.s    = 1'b1;
    @(posedge clk);
    #1;
    bus16.s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset16 = 1'b1;
    @(posedge clk);
    #1;
    reset16 = 1'b0;
    n_checks++;
    if (bus16.w !== 1'b1 || bus16.out !== 16'h0000)
      begin n_fail++; $display("FAIL rst_mid_w_out: got w=%b out=%h want 1/0000", bus16.w, bus16.out); end
    n_checks++;
    if ({bus16.N, bus16.V, bus16.Z, bus16.err} !== 4'b0000)
      begin n_fail++; $display("FAIL rst_mid_flags: got NVZ,err=%b want 0000", {bus16.N, bus16.V, bus16.Z, bus16.err}); end
    n_checks++;
    if (dut16.r_q[2] !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_r2: got %h want 0000", dut16.r_q[2]); end
    run16(16'hC062, lat);
    n_checks++;
    if (lat != 5 || bus16.out !== 16'h0000)
      begin n_fail++; $display("FAIL rst_mid_movr: got lat=%0d out=%h want 5/0000", lat, bus16.out); end
  endtask

  initial begin
    reset16    = 1'b1;
    reset8     = 1'b1;
    bus16.s    = 1'b0;
    bus16.load = 1'b0;
    bus16.in   = 16'h0000;
    bus8.s     = 1'b0;
    bus8.load  = 1'b0;
    bus8.in    = 16'h0000;

    test_reset();
    test_add_seq();
    test_cmp();
    test_overflow_shift();
    test_width8();
    test_undefined();
    test_back_to_back();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
